// File: rtl/tankwar_pkg.sv
// Shared constants for the tank-war design plus the arithmetic that turns a
// clock frequency and an output period into divider terminal counts.
package tankwar_pkg;

  localparam longint unsigned CLK_FREQ_HZ_DEF = 64'd100_000_000;
  localparam longint unsigned GAME_TICK_MS    = 64'd500;

  // Clocks per half period; 64-bit so large frequencies cannot overflow,
  // integer division truncates toward zero.
  function automatic longint unsigned calc_half_count(input longint unsigned freq_hz,
                                                      input longint unsigned period_ms);
    return freq_hz / 64'd1000 * period_ms / 64'd2;
  endfunction

  // Counter width able to hold 0 .. half_count-1, never narrower than one bit.
  function automatic int unsigned calc_cnt_w(input longint unsigned half_count);
    if (half_count <= 64'd1) return 1;
    return $clog2(half_count);
  endfunction

endpackage

// File: rtl/clk_500ms_if.sv
// Output bundle of the game-loop time base. The tick_500ms signal only exists
// when the CLK500_TICK_EN macro is defined.
interface clk_500ms_if;

  logic clk_500ms;
`ifdef CLK500_TICK_EN
  logic tick_500ms;

  modport master (output clk_500ms, output tick_500ms);
  modport slave  (input  clk_500ms, input  tick_500ms);
`else
  modport master (output clk_500ms);
  modport slave  (input  clk_500ms);
`endif

endinterface

// File: rtl/mod_counter.sv
// Free-running modulo-MOD counter. wrap is high combinationally while the
// count sits on its last value, so the owner can act in the same cycle the
// counter returns to zero.
module mod_counter #(
  parameter longint unsigned MOD = 2,
  parameter int unsigned     W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 64'd1);

  logic [W-1:0] r_cnt;

  // Count up, returning to zero on the cycle after the last value.
  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  // NOTE: reset is asynchronous, listed in the sensitivity list, so the
  // counter clears the instant rst rises rather than at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (wrap) r_cnt <= '0;
    else           r_cnt <= r_cnt + W'(1);
  end

  assign wrap = (r_cnt == LAST);
  assign cnt  = r_cnt;

endmodule

// File: rtl/clk_500ms.sv
// Game-loop time base: divides clk_100mhz into a 50%-duty square wave of
// PERIOD_MS milliseconds. clk_500ms is a registered data signal, to be
// edge-detected in the clk_100mhz domain, never used as a clock.
// Optional feature macro: CLK500_TICK_EN adds tick_500ms, a one-cycle pulse
// coincident with each 0->1 transition of clk_500ms.
module clk_500ms
  import tankwar_pkg::*;
#(
  parameter longint unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
  parameter longint unsigned PERIOD_MS   = GAME_TICK_MS
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  clk_500ms_if.master bus
);

  localparam longint unsigned HALF_COUNT = calc_half_count(CLK_FREQ_HZ, PERIOD_MS);
  localparam int unsigned     CNT_W      = calc_cnt_w(HALF_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HALF_COUNT - 64'd1);

  // A zero half period cannot produce any waveform.
  if (HALF_COUNT < 64'd1) begin : g_bad_half_count
    $error("clk_500ms: HALF_COUNT must be at least 1 (CLK_FREQ_HZ/1000*PERIOD_MS/2)");
  end

  logic [CNT_W-1:0] w_cnt;
  logic             w_wrap;
  logic             r_clk_500ms;

  mod_counter #(
    .MOD (HALF_COUNT),
    .W   (CNT_W)
  ) u_half_cnt (
    .clk  (clk_100mhz),
    .rst  (rst),
    .cnt  (w_cnt),
    .wrap (w_wrap)
  );

  // Flip the square wave every HALF_COUNT clocks, on the counter's wrap.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst)         r_clk_500ms <= 1'b0;
    else if (w_wrap) r_clk_500ms <= ~r_clk_500ms;
  end

  assign bus.clk_500ms = r_clk_500ms;

`ifdef CLK500_TICK_EN
  logic r_tick_500ms;

  // Pulse for one cycle when the wave is about to go 0->1, so the pulse
  // lands in the same cycle the wave reads high for the first time.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) r_tick_500ms <= 1'b0;
    else     r_tick_500ms <= w_wrap & ~r_clk_500ms;
  end

  assign bus.tick_500ms = r_tick_500ms;
`endif

  // The counter must stay inside 0 .. HALF_COUNT-1.
  a_cnt_in_range : assert property (
    @(posedge clk_100mhz) disable iff (rst) (w_cnt <= CNT_LAST)
  );

endmodule

// File: tb/tb_clk_500ms.sv
// Self-checking bench for clk_500ms. Three instances share clock and reset:
// a scaled one (HALF_COUNT=5), the fastest legal one (HALF_COUNT=1) and the
// default-parameter one. A reference model counts rising edges since reset
// release and derives the expected wave and tick from that count alone.
module tb_clk_500ms;

  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  localparam longint unsigned HC_A   = 64'd1000 / 64'd1000 * 64'd10 / 64'd2;
  localparam longint unsigned HC_B   = 64'd2000 / 64'd1000 * 64'd1 / 64'd2;
  localparam longint unsigned HC_DEF = 64'd100_000_000 / 64'd1000 * 64'd500 / 64'd2;

  clk_500ms_if if_a ();
  clk_500ms_if if_b ();
  clk_500ms_if if_c ();

  clk_500ms #(.CLK_FREQ_HZ(1000), .PERIOD_MS(10)) dut_a (
    .clk_100mhz (clk), .rst (rst), .bus (if_a)
  );
  clk_500ms #(.CLK_FREQ_HZ(2000), .PERIOD_MS(1)) dut_b (
    .clk_100mhz (clk), .rst (rst), .bus (if_b)
  );
  clk_500ms dut_c (
    .clk_100mhz (clk), .rst (rst), .bus (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: rising edges seen since reset was last released.
  longint unsigned n_edges;
  always @(posedge clk or posedge rst) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  function automatic logic exp_wave(input longint unsigned n, input longint unsigned hc);
    return ((n / hc) % 2) == 1;
  endfunction

  function automatic logic exp_tick(input longint unsigned n, input longint unsigned hc);
    return (n != 0) && ((n % (2 * hc)) == hc);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t, edges=%0d)", tag, act, exp, $time, n_edges);
    end
  endtask

  task automatic check_all();
    check("a_wave", 64'(if_a.clk_500ms), 64'(exp_wave(n_edges, HC_A)));
    check("b_wave", 64'(if_b.clk_500ms), 64'(exp_wave(n_edges, HC_B)));
    check("c_wave", 64'(if_c.clk_500ms), 64'(exp_wave(n_edges, HC_DEF)));
`ifdef CLK500_TICK_EN
    check("a_tick", 64'(if_a.tick_500ms), 64'(exp_tick(n_edges, HC_A)));
    check("b_tick", 64'(if_b.tick_500ms), 64'(exp_tick(n_edges, HC_B)));
    check("c_tick", 64'(if_c.tick_500ms), 64'(exp_tick(n_edges, HC_DEF)));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_wave"}, 64'(if_a.clk_500ms), 64'd0);
    check({tag, "_b_wave"}, 64'(if_b.clk_500ms), 64'd0);
`ifdef CLK500_TICK_EN
    check({tag, "_a_tick"}, 64'(if_a.tick_500ms), 64'd0);
    check({tag, "_b_tick"}, 64'(if_b.tick_500ms), 64'd0);
`endif
  endtask

  // Run cycles, checking everything on the falling edge.
  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
  endtask

  // Raise rst a few ns after a rising edge, confirm outputs drop at once,
  // hold for a few cycles and release on a falling edge.
  task automatic async_reset(input int offset_ns, input int hold_cycles);
    @(posedge clk);
    #(offset_ns);
    rst = 1'b1;
    #1;
    check_zero("async");
    @(negedge clk);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      check_zero("hold");
    end
    rst = 1'b0;
  endtask

  initial begin
    int prev_a;
    int rises;
    int ticks;

    rst = 1'b1;

    // Elaborated constants of the default build.
    check("hc_default",   64'(dut_c.HALF_COUNT), HC_DEF);
    check("cntw_default", 64'(dut_c.CNT_W),      64'd25);
    check("cntw_scaled",  64'(dut_a.CNT_W),      64'd3);

    // Held in reset for three clocks.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_zero("in_reset");
    end
    rst = 1'b0;

    // Free-run 40 clocks; the scaled wave must rise at edges 5, 15, 25, 35.
    prev_a = 0;
    rises  = 0;
    ticks  = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
      if (i == 5) check("first_rise", 64'(if_a.clk_500ms), 64'd1);
      if (prev_a == 0 && if_a.clk_500ms == 1'b1) rises++;
      prev_a = int'(if_a.clk_500ms);
`ifdef CLK500_TICK_EN
      if (if_a.tick_500ms == 1'b1) ticks++;
`endif
    end
    check("rise_count", 64'(rises), 64'd4);
`ifdef CLK500_TICK_EN
    check("tick_count", 64'(ticks), 64'd4);
`endif

    // Move into the high phase (edges 45..49), then reset between edges.
    run(7);
    check("high_phase", 64'(if_a.clk_500ms), 64'd1);
    async_reset(3, 1);

    // Rise again exactly five edges after release.
    run(4);
    check("pre_rise", 64'(if_a.clk_500ms), 64'd0);
    run(1);
    check("re_rise", 64'(if_a.clk_500ms), 64'd1);

    // Random run lengths interleaved with random asynchronous resets.
    for (int r = 0; r < 12; r++) begin
      run(int'($urandom_range(1, 30)));
      async_reset(int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
    end
    run(25);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
